// File: rtl/tl_a_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one TileLink A/D channel pair
// between NumHosts requesters. The host index is prepended to the A source
// and D responses are steered back by those bits.
module tl_a_burst_arbiter #(
   parameter int unsigned NumHosts    = 2,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned AddrWidth   = 56,
   parameter int unsigned SourceWidth = 1,
   parameter int unsigned SinkWidth   = 1,
   parameter int unsigned MaxSize     = 6,
   localparam int unsigned IdxW     = $clog2(NumHosts),
   localparam int unsigned NonBurst = $clog2(DataWidth / 8),
   localparam int unsigned BeatW    = MaxSize - NonBurst + 1,
   localparam int unsigned MaskW    = DataWidth / 8,
   localparam int unsigned AHostW   = 10 + SourceWidth + AddrWidth + MaskW + 1 + DataWidth,
   localparam int unsigned ADevW    = AHostW + IdxW,
   localparam int unsigned DHostW   = 9 + SourceWidth + SinkWidth + 2 + DataWidth,
   localparam int unsigned DDevW    = DHostW + IdxW
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumHosts-1:0]              host_a_valid_i,
   output logic [NumHosts-1:0]              host_a_ready_o,
   input  logic [NumHosts-1:0][AHostW-1:0]  host_a_i,
   output logic [NumHosts-1:0]              host_d_valid_o,
   input  logic [NumHosts-1:0]              host_d_ready_i,
   output logic [DHostW-1:0]                host_d_o,
   output logic                             device_a_valid_o,
   input  logic                             device_a_ready_i,
   output logic [ADevW-1:0]                 device_a_o,
   input  logic                             device_d_valid_i,
   output logic                             device_d_ready_o,
   input  logic [DDevW-1:0]                 device_d_i
);

   // Split points: everything below the source field stays in place, the host
   // index is inserted as the new source MSBs.
   localparam int unsigned ASplit = AddrWidth + MaskW + 1 + DataWidth + SourceWidth;
   localparam int unsigned DSplit = SinkWidth + 2 + DataWidth + SourceWidth;

   logic [IdxW-1:0]   ptr_q, ptr_d, sel_q, sel_d, sel;
   logic              lock_q, lock_d;
   logic [BeatW-1:0]  left_q, left_d;
   logic              any_valid, accept;
   logic [AHostW-1:0] a_sel;
   logic [2:0]        a_op;
   logic [3:0]        a_size;
   logic [BeatW-1:0]  first_left;
   logic [IdxW-1:0]   d_idx;
   logic              d_ready;

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
      if (x == IdxW'(NumHosts - 1)) return '0;
      return x + IdxW'(1);
   endfunction

   // Pick the presented host: held selection when locked, else round-robin scan
   always_comb begin
      int unsigned j;
      j         = 0;
      sel       = ptr_q;
      any_valid = 1'b0;
      if (lock_q) begin
         sel       = sel_q;
         any_valid = host_a_valid_i[sel_q];
      end else begin
         for (int unsigned k = 0; k < NumHosts; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NumHosts) j = j - NumHosts;
            if (!any_valid && host_a_valid_i[IdxW'(j)]) begin
               sel       = IdxW'(j);
               any_valid = 1'b1;
            end
         end
      end
   end

   assign a_sel  = host_a_i[sel];
   assign a_op   = a_sel[AHostW-1 -: 3];
   assign a_size = a_sel[AHostW-7 -: 4];

   // Beats remaining after the first beat of a fresh transfer
   always_comb begin
      first_left = '0;
      if (!a_op[2] && (32'(a_size) > NonBurst)) begin
         first_left = BeatW'((32'd1 << (32'(a_size) - NonBurst)) - 32'd1);
      end
   end

   // A channel pass-through with source extension; everything gated in reset
   always_comb begin
      device_a_valid_o = any_valid & ~rst_i;
      host_a_ready_o   = '0;
      if (!rst_i) host_a_ready_o[sel] = device_a_ready_i;
      device_a_o       = {a_sel[AHostW-1:ASplit], sel, a_sel[ASplit-1:0]};
      accept           = device_a_valid_o & device_a_ready_i;
   end

   // Burst tracking: lock on a stalled or multi-beat transfer, release on last beat
   always_comb begin
      ptr_d  = ptr_q;
      sel_d  = sel_q;
      lock_d = lock_q;
      left_d = left_q;
      if (accept) begin
         if (!lock_q || (left_q == '0)) begin
            if (first_left != '0) begin
               lock_d = 1'b1;
               sel_d  = sel;
               left_d = first_left;
            end else begin
               lock_d = 1'b0;
               ptr_d  = next_idx(sel);
            end
         end else begin
            left_d = left_q - BeatW'(1);
            if (left_q == BeatW'(1)) begin
               lock_d = 1'b0;
               ptr_d  = next_idx(sel_q);
            end
         end
      end else if (device_a_valid_o && !lock_q) begin
         // Stalled beat: freeze the choice so a new requester cannot swap it
         lock_d = 1'b1;
         sel_d  = sel;
         left_d = '0;
      end
   end

   // Arbitration state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q  <= '0;
         sel_q  <= '0;
         lock_q <= 1'b0;
         left_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         sel_q  <= sel_d;
         lock_q <= lock_d;
         left_q <= left_d;
      end
   end

   assign d_idx    = device_d_i[DSplit+IdxW-1 -: IdxW];
   assign host_d_o = {device_d_i[DDevW-1:DSplit+IdxW], device_d_i[DSplit-1:0]};

   // D routing by source MSBs; unknown index is drained so the device never stalls
   always_comb begin
      host_d_valid_o = '0;
      d_ready        = 1'b1;
      for (int unsigned i = 0; i < NumHosts; i++) begin
         if (d_idx == IdxW'(i)) begin
            host_d_valid_o[i] = device_d_valid_i & ~rst_i;
            d_ready           = host_d_ready_i[i];
         end
      end
      device_d_ready_o = d_ready & ~rst_i;
   end

   // A host must keep its beat valid for as long as it holds the grant
   a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      lock_q |-> host_a_valid_i[sel_q]);

   // Responses must carry a host index that exists
   d_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
      device_d_valid_i |-> (32'(d_idx) < NumHosts));

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// Bench for tl_a_burst_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_tl_a_burst_arbiter;

   localparam int N  = 2;
   localparam int DW = 64;
   localparam int AW = 56;
   localparam int SW = 1;
   localparam int KW = 1;
   localparam int IW = 1;
   localparam int MW = DW / 8;
   localparam int AH = 10 + SW + AW + MW + 1 + DW;
   localparam int AD = AH + IW;
   localparam int DH = 9 + SW + KW + 2 + DW;
   localparam int DD = DH + IW;

   typedef struct {
      logic [2:0]    op;
      logic [3:0]    size;
      logic [SW-1:0] src;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      beat_t b;
      int    h;
   } exp_t;

   typedef struct {
      logic [2:0]    op;
      logic [1:0]    prm;
      logic [3:0]    size;
      logic [SW-1:0] src;
      logic [KW-1:0] sink;
      logic          den;
      logic          cor;
      logic [DW-1:0] data;
   } dbeat_t;

   logic                   clk = 1'b0;
   logic                   rst_i = 1'b1;
   logic [N-1:0]           host_a_valid_i = '0;
   logic [N-1:0]           host_a_ready_o;
   logic [N-1:0][AH-1:0]   host_a_i = '0;
   logic [N-1:0]           host_d_valid_o;
   logic [N-1:0]           host_d_ready_i = '0;
   logic [DH-1:0]          host_d_o;
   logic                   device_a_valid_o;
   logic                   device_a_ready_i = 1'b0;
   logic [AD-1:0]          device_a_o;
   logic                   device_d_valid_i = 1'b0;
   logic                   device_d_ready_o;
   logic [DD-1:0]          device_d_i = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tl_a_burst_arbiter #(
      .NumHosts(N), .DataWidth(DW), .AddrWidth(AW),
      .SourceWidth(SW), .SinkWidth(KW), .MaxSize(6)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .host_a_valid_i(host_a_valid_i), .host_a_ready_o(host_a_ready_o),
      .host_a_i(host_a_i),
      .host_d_valid_o(host_d_valid_o), .host_d_ready_i(host_d_ready_i),
      .host_d_o(host_d_o),
      .device_a_valid_o(device_a_valid_o), .device_a_ready_i(device_a_ready_i),
      .device_a_o(device_a_o),
      .device_d_valid_i(device_d_valid_i), .device_d_ready_o(device_d_ready_o),
      .device_d_i(device_d_i)
   );

   function automatic logic [AH-1:0] mk_a(beat_t b);
      return {b.op, 3'b000, b.size, b.src, b.addr, {MW{1'b1}}, 1'b0, b.data};
   endfunction

   function automatic logic [AD-1:0] mk_dev(beat_t b, int h);
      return {b.op, 3'b000, b.size, IW'(h), b.src, b.addr, {MW{1'b1}}, 1'b0, b.data};
   endfunction

   function automatic logic [DD-1:0] mk_dd(dbeat_t d, int h);
      return {d.op, d.prm, d.size, IW'(h), d.src, d.sink, d.den, d.cor, d.data};
   endfunction

   function automatic logic [DH-1:0] mk_dh(dbeat_t d);
      return {d.op, d.prm, d.size, d.src, d.sink, d.den, d.cor, d.data};
   endfunction

   function automatic beat_t rnd_beat(logic [2:0] op, logic [3:0] size);
      beat_t b;
      b.op   = op;
      b.size = size;
      b.src  = SW'($urandom);
      b.addr = AW'({$urandom, $urandom});
      b.data = {$urandom, $urandom};
      return b;
   endfunction

   // Beats on the wire for one transfer, from the TileLink size/opcode rules
   function automatic int n_beats(logic [2:0] op, logic [3:0] size);
      if (op <= 3'd3 && int'(size) > 3) return 1 << (int'(size) - 3);
      return 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i            = 1'b1;
      host_a_valid_i   = '1;
      device_a_ready_i = 1'b1;
      device_d_valid_i = 1'b1;
      host_d_ready_i   = '1;
      device_d_i       = '0;
      #1;
      n_cmp += 4;
      if (device_a_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_a_valid: got %b want 0", device_a_valid_o);
      end
      if (host_a_ready_o !== 2'b00) begin
         n_bad++; $display("FAIL reset_a_ready: got %b want 00", host_a_ready_o);
      end
      if (host_d_valid_o !== 2'b00) begin
         n_bad++; $display("FAIL reset_d_valid: got %b want 00", host_d_valid_o);
      end
      if (device_d_ready_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_d_ready: got %b want 0", device_d_ready_o);
      end
      tick();
      rst_i            = 1'b0;
      host_a_valid_i   = '0;
      device_a_ready_i = 1'b0;
      device_d_valid_i = 1'b0;
      host_d_ready_i   = '0;
      tick();
   endtask

   task automatic test_round_robin();
      beat_t hb [N];
      for (int h = 0; h < N; h++) begin
         hb[h] = rnd_beat(3'd4, 4'd3);
         host_a_i[h] = mk_a(hb[h]);
      end
      host_a_valid_i   = 2'b11;
      device_a_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(hb[c % 2], c % 2) || host_a_ready_o !== 2'(1 << (c % 2))
             || device_a_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_grant[%0d]: got rdy=%b a=%h want rdy=%b a=%h", c, host_a_ready_o,
                     device_a_o, 2'(1 << (c % 2)), mk_dev(hb[c % 2], c % 2));
         end
         tick();
      end
      host_a_valid_i = '0;
      tick();
   endtask

   task automatic test_burst();
      beat_t b1, b0;
      b0 = rnd_beat(3'd4, 4'd3);
      host_a_i[0]      = mk_a(b0);
      host_a_valid_i   = 2'b10;
      device_a_ready_i = 1'b1;
      b1 = rnd_beat(3'd0, 4'd6);
      for (int k = 0; k < 8; k++) begin
         b1.data = {$urandom, $urandom};
         host_a_i[1] = mk_a(b1);
         if (k == 1) host_a_valid_i = 2'b11;
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(b1, 1) || host_a_ready_o !== 2'b10) begin
            n_bad++;
            $display("FAIL burst_beat[%0d]: got rdy=%b a=%h want rdy=10 a=%h", k,
                     host_a_ready_o, device_a_o, mk_dev(b1, 1));
         end
         tick();
      end
      b1 = rnd_beat(3'd4, 4'd2);
      host_a_i[1] = mk_a(b1);
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b0, 0) || host_a_ready_o !== 2'b01) begin
         n_bad++;
         $display("FAIL burst_release: got rdy=%b a=%h want rdy=01 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b0, 0));
      end
      tick();
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b1, 1) || host_a_ready_o !== 2'b10) begin
         n_bad++;
         $display("FAIL burst_after: got rdy=%b a=%h want rdy=10 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b1, 1));
      end
      tick();
      host_a_valid_i = '0;
      tick();
   endtask

   task automatic test_hold();
      beat_t b0, b1;
      // One accepted host-0 beat puts host 1 at the head of the rotation
      b0 = rnd_beat(3'd4, 4'd3);
      host_a_i[0]      = mk_a(b0);
      host_a_valid_i   = 2'b01;
      device_a_ready_i = 1'b1;
      tick();
      b0 = rnd_beat(3'd4, 4'd3);
      b1 = rnd_beat(3'd4, 4'd3);
      host_a_i[0]      = mk_a(b0);
      host_a_i[1]      = mk_a(b1);
      device_a_ready_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) host_a_valid_i = 2'b11;
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(b0, 0) || device_a_valid_o !== 1'b1
             || host_a_ready_o !== 2'b00) begin
            n_bad++;
            $display("FAIL hold[%0d]: got v=%b rdy=%b a=%h want v=1 rdy=00 a=%h", c,
                     device_a_valid_o, host_a_ready_o, device_a_o, mk_dev(b0, 0));
         end
         tick();
      end
      device_a_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b0, 0) || host_a_ready_o !== 2'b01) begin
         n_bad++;
         $display("FAIL hold_accept: got rdy=%b a=%h want rdy=01 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b0, 0));
      end
      tick();
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b1, 1) || host_a_ready_o !== 2'b10) begin
         n_bad++;
         $display("FAIL hold_next: got rdy=%b a=%h want rdy=10 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b1, 1));
      end
      tick();
      host_a_valid_i = '0;
      tick();
   endtask

   task automatic test_d_route();
      dbeat_t d;
      logic [1:0] exp_v;
      logic       exp_r;
      d = '{op: 3'd1, prm: 2'd0, size: 4'd3, src: 1'b0, sink: 1'b1, den: 1'b0, cor: 1'b0,
            data: 64'h0123_4567_89ab_cdef};
      device_d_i       = mk_dd(d, 1);
      device_d_valid_i = 1'b1;
      host_d_ready_i   = 2'b01;
      #1;
      n_cmp++;
      if (host_d_valid_o !== 2'b10 || device_d_ready_o !== 1'b0 || host_d_o !== mk_dh(d)) begin
         n_bad++;
         $display("FAIL d_stall: got v=%b r=%b d=%h want v=10 r=0 d=%h", host_d_valid_o,
                  device_d_ready_o, host_d_o, mk_dh(d));
      end
      tick();
      host_d_ready_i = 2'b11;
      #1;
      n_cmp++;
      if (host_d_valid_o !== 2'b10 || device_d_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL d_complete: got v=%b r=%b want v=10 r=1", host_d_valid_o,
                  device_d_ready_o);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         int h;
         h = int'($urandom_range(0, 1));
         d.op = 3'($urandom); d.prm = 2'($urandom); d.size = 4'($urandom);
         d.src = SW'($urandom); d.sink = KW'($urandom); d.den = 1'($urandom);
         d.cor = 1'($urandom); d.data = {$urandom, $urandom};
         device_d_i       = mk_dd(d, h);
         device_d_valid_i = 1'($urandom);
         host_d_ready_i   = 2'($urandom);
         exp_v = device_d_valid_i ? 2'(1 << h) : 2'b00;
         exp_r = host_d_ready_i[h];
         #1;
         n_cmp++;
         if (host_d_valid_o !== exp_v || device_d_ready_o !== exp_r || host_d_o !== mk_dh(d)) begin
            n_bad++;
            $display("FAIL d_rand[%0d]: got v=%b r=%b d=%h want v=%b r=%b d=%h", i,
                     host_d_valid_o, device_d_ready_o, host_d_o, exp_v, exp_r, mk_dh(d));
         end
         tick();
      end
      device_d_valid_i = 1'b0;
      host_d_ready_i   = '0;
   endtask

   task automatic test_reset_mid_burst();
      beat_t b0, b1;
      b0 = rnd_beat(3'd0, 4'd6);
      b1 = rnd_beat(3'd4, 4'd3);
      host_a_i[1]      = mk_a(b1);
      host_a_valid_i   = 2'b11;
      device_a_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b0.data = {$urandom, $urandom};
         host_a_i[0] = mk_a(b0);
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(b0, 0) || host_a_ready_o !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_burst[%0d]: got rdy=%b a=%h want rdy=01 a=%h", k,
                     host_a_ready_o, device_a_o, mk_dev(b0, 0));
         end
         tick();
      end
      device_d_valid_i = 1'b1;
      host_d_ready_i   = 2'b11;
      device_d_i       = '0;
      rst_i            = 1'b1;
      #1;
      n_cmp++;
      if (device_a_valid_o !== 1'b0 || host_a_ready_o !== 2'b00 || host_d_valid_o !== 2'b00
          || device_d_ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid: got av=%b ar=%b dv=%b dr=%b want all 0", device_a_valid_o,
                  host_a_ready_o, host_d_valid_o, device_d_ready_o);
      end
      tick();
      rst_i            = 1'b0;
      device_d_valid_i = 1'b0;
      host_d_ready_i   = '0;
      b0 = rnd_beat(3'd4, 4'd3);
      host_a_i[0] = mk_a(b0);
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b0, 0) || host_a_ready_o !== 2'b01) begin
         n_bad++;
         $display("FAIL rst_tie: got rdy=%b a=%h want rdy=01 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b0, 0));
      end
      tick();
      #1;
      n_cmp++;
      if (device_a_o !== mk_dev(b1, 1) || host_a_ready_o !== 2'b10) begin
         n_bad++;
         $display("FAIL rst_unlocked: got rdy=%b a=%h want rdy=10 a=%h", host_a_ready_o,
                  device_a_o, mk_dev(b1, 1));
      end
      tick();
      host_a_valid_i = '0;
      tick();
   endtask

   task automatic test_single_beat();
      logic [2:0] ops [3]   = '{3'd1, 3'd0, 3'd4};
      logic [3:0] sizes [3] = '{4'd2, 4'd3, 4'd6};
      beat_t b0, b1;
      device_a_ready_i = 1'b1;
      for (int t = 0; t < 3; t++) begin
         b0 = rnd_beat(ops[t], sizes[t]);
         host_a_i[0]    = mk_a(b0);
         host_a_valid_i = 2'b01;
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(b0, 0) || host_a_ready_o !== 2'b01) begin
            n_bad++;
            $display("FAIL single[%0d]: got rdy=%b a=%h want rdy=01 a=%h", t, host_a_ready_o,
                     device_a_o, mk_dev(b0, 0));
         end
         tick();
         b0 = rnd_beat(3'd4, 4'd3);
         b1 = rnd_beat(3'd4, 4'd3);
         host_a_i[0]    = mk_a(b0);
         host_a_i[1]    = mk_a(b1);
         host_a_valid_i = 2'b11;
         #1;
         n_cmp++;
         if (device_a_o !== mk_dev(b1, 1) || host_a_ready_o !== 2'b10) begin
            n_bad++;
            $display("FAIL single_next[%0d]: got rdy=%b a=%h want rdy=10 a=%h", t,
                     host_a_ready_o, device_a_o, mk_dev(b1, 1));
         end
         tick();
         host_a_valid_i = '0;
      end
      tick();
   endtask

   task automatic test_random();
      beat_t hq [N][$];
      beat_t mq [N][$];
      int    plen [N][$];
      exp_t  exp_q [$];
      int    ptr, found, cycles;
      logic [2:0] op_tab [3] = '{3'd0, 3'd1, 3'd4};
      rst_i = 1'b1;
      host_a_valid_i = '0;
      tick();
      rst_i = 1'b0;
      for (int h = 0; h < N; h++) begin
         int np;
         np = int'($urandom_range(4, 8));
         for (int p = 0; p < np; p++) begin
            logic [2:0] op;
            logic [3:0] sz;
            beat_t b;
            op = op_tab[$urandom_range(0, 2)];
            sz = 4'($urandom_range(0, 6));
            b  = rnd_beat(op, sz);
            plen[h].push_back(n_beats(op, sz));
            for (int k = 0; k < n_beats(op, sz); k++) begin
               b.data = {$urandom, $urandom};
               hq[h].push_back(b);
            end
         end
         mq[h] = hq[h];
      end
      // Whole transfers taken round-robin over hosts with work left
      ptr = 0;
      forever begin
         found = -1;
         for (int k = 0; k < N; k++) begin
            if (found < 0 && plen[(ptr + k) % N].size() > 0) found = (ptr + k) % N;
         end
         if (found < 0) break;
         repeat (plen[found].pop_front()) exp_q.push_back('{b: mq[found].pop_front(), h: found});
         ptr = (found + 1) % N;
      end
      cycles = 0;
      while (exp_q.size() > 0 && cycles < 5000) begin
         for (int h = 0; h < N; h++) begin
            host_a_valid_i[h] = hq[h].size() > 0;
            if (hq[h].size() > 0) host_a_i[h] = mk_a(hq[h][0]);
         end
         device_a_ready_i = $urandom_range(0, 3) != 0;
         #1;
         if (device_a_valid_o && device_a_ready_i) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (device_a_o !== mk_dev(e.b, e.h) || host_a_ready_o !== 2'(1 << e.h)) begin
               n_bad++;
               $display("FAIL rand_beat: got rdy=%b a=%h want rdy=%b a=%h", host_a_ready_o,
                        device_a_o, 2'(1 << e.h), mk_dev(e.b, e.h));
            end
         end
         for (int h = 0; h < N; h++) begin
            if (host_a_valid_i[h] && host_a_ready_o[h] && device_a_ready_i) void'(hq[h].pop_front());
         end
         tick();
         cycles++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rand_timeout: got %0d beats left want 0", exp_q.size());
      end
      host_a_valid_i   = '0;
      device_a_ready_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst();
      test_hold();
      test_d_route();
      test_reset_mid_burst();
      test_single_beat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
